// File: rtl/rf_wb_scheduler.sv
// Register-file write-back scheduler: round-robin arbitration of NREQ write-back
// requesters onto one registered RF write port, plus a pending-register scoreboard.
module rf_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int AW   = 6,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        rf_W,
  output logic [DW-1:0]        rf_Data_in,
  output logic                 rf_W_en,
  input  logic                 claim_valid,
  input  logic [AW-1:0]        claim_addr,
  output logic                 claim_err,
  input  logic [AW-1:0]        rd1_addr,
  input  logic [AW-1:0]        rd2_addr,
  output logic                 rd1_busy,
  output logic                 rd2_busy,
  output logic [AW:0]          pend_count
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   scan_idx;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            same_addr;
  logic            claim_hit;
  logic            clear_hit;
  logic            claim_err_nxt;
  logic [AW:0]     count_nxt;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin : arbiter
    req_ready = '0;
    xfer      = 1'b0;
    next_ptr  = rr_ptr;
    scan_idx  = '0;
    sel_addr  = '0;
    sel_data  = '0;
    if (reset) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = PW'((int'(rr_ptr) + k) % NREQ);
        if (!xfer && req_valid[scan_idx]) begin
          xfer                = 1'b1;
          req_ready[scan_idx] = 1'b1;
          sel_addr            = addr_arr[scan_idx];
          sel_data            = data_arr[scan_idx];
          next_ptr            = PW'((int'(scan_idx) + 1) % NREQ);
        end
      end
    end
  end

  // Set beats clear on the same register; the count moves only on real 0<->1 flips.
  always_comb begin : scoreboard
    pending_nxt   = pending;
    same_addr     = xfer && (sel_addr == claim_addr);
    claim_hit     = claim_valid && !pending[claim_addr];
    clear_hit     = xfer && pending[sel_addr] && !(claim_valid && same_addr);
    claim_err_nxt = claim_valid && pending[claim_addr] && !same_addr;
    if (xfer)        pending_nxt[sel_addr]   = 1'b0;
    if (claim_valid) pending_nxt[claim_addr] = 1'b1;
    count_nxt = pend_count + (AW+1)'(claim_hit) - (AW+1)'(clear_hit);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: pending is a flop vector rather than a RAM, so clearing it in reset is legal.
      pending    <= '0;
      pend_count <= '0;
      rr_ptr     <= '0;
      rf_W_en    <= 1'b0;
      rf_W       <= '0;
      rf_Data_in <= '0;
      claim_err  <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      pend_count <= count_nxt;
      claim_err  <= claim_err_nxt;
      rf_W_en    <= xfer;
      if (xfer) begin
        rr_ptr     <= next_ptr;
        rf_W       <= sel_addr;
        rf_Data_in <= sel_data;
      end
    end
  end

  assign rd1_busy = pending[rd1_addr];
  assign rd2_busy = pending[rd2_addr];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed vector table, a mid-stream
// reset sequence, and randomized traffic against a behavioural model.
module tb_rf_wb_scheduler;

  localparam int NREQ = 3;
  localparam int AW   = 6;
  localparam int DW   = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [AW-1:0]       rf_W;
  logic [DW-1:0]       rf_Data_in;
  logic                rf_W_en;
  logic                claim_valid;
  logic [AW-1:0]       claim_addr;
  logic                claim_err;
  logic [AW-1:0]       rd1_addr;
  logic [AW-1:0]       rd2_addr;
  logic                rd1_busy;
  logic                rd2_busy;
  logic [AW:0]         pend_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rf_W       (rf_W),
    .rf_Data_in (rf_Data_in),
    .rf_W_en    (rf_W_en),
    .claim_valid(claim_valid),
    .claim_addr (claim_addr),
    .claim_err  (claim_err),
    .rd1_addr   (rd1_addr),
    .rd2_addr   (rd2_addr),
    .rd1_busy   (rd1_busy),
    .rd2_busy   (rd2_busy),
    .pend_count (pend_count)
  );

  // Inputs for one cycle, and the outputs expected when sampled in that same cycle
  // (registered outputs reflect the edges before it).
  typedef struct {
    logic               rst;
    logic [NREQ-1:0]    valid;
    logic [NREQ*AW-1:0] a_bus;
    logic [NREQ*DW-1:0] d_bus;
    logic               cv;
    logic [AW-1:0]      ca;
    logic [AW-1:0]      r1;
    logic [NREQ-1:0]    e_ready;
    logic               e_wen;
    logic [AW-1:0]      e_w;
    logic [DW-1:0]      e_d;
    logic               e_busy;
    logic [AW:0]        e_cnt;
    logic               e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rst, int v, int a0, int a1, int a2, int d0, int d1, int d2,
                              int cv, int ca, int r1,
                              int er, int ew, int eaddr, int edata, int eb, int ec, int ee);
    vec_t r;
    r.rst     = rst[0];
    r.valid   = NREQ'(v);
    r.a_bus   = {AW'(a2), AW'(a1), AW'(a0)};
    r.d_bus   = {DW'(d2), DW'(d1), DW'(d0)};
    r.cv      = cv[0];
    r.ca      = AW'(ca);
    r.r1      = AW'(r1);
    r.e_ready = NREQ'(er);
    r.e_wen   = ew[0];
    r.e_w     = AW'(eaddr);
    r.e_d     = DW'(edata);
    r.e_busy  = eb[0];
    r.e_cnt   = (AW+1)'(ec);
    r.e_err   = ee[0];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    reset       = v.rst;
    req_valid   = v.valid;
    req_addr    = v.a_bus;
    req_data    = v.d_bus;
    claim_valid = v.cv;
    claim_addr  = v.ca;
    rd1_addr    = v.r1;
    rd2_addr    = '0;
    #1;
    check($sformatf("row%0d req_ready", row),  64'(req_ready),  64'(v.e_ready));
    check($sformatf("row%0d rf_W_en", row),    64'(rf_W_en),    64'(v.e_wen));
    check($sformatf("row%0d rf_W", row),       64'(rf_W),       64'(v.e_w));
    check($sformatf("row%0d rf_Data_in", row), 64'(rf_Data_in), 64'(v.e_d));
    check($sformatf("row%0d rd1_busy", row),   64'(rd1_busy),   64'(v.e_busy));
    check($sformatf("row%0d pend_count", row), 64'(pend_count), 64'(v.e_cnt));
    check($sformatf("row%0d claim_err", row),  64'(claim_err),  64'(v.e_err));
    @(negedge clk);
  endtask

  // Behavioural reference state for the random phase.
  bit          m_pend [64];
  int          m_ptr;
  logic        m_wen;
  logic [AW-1:0] m_w;
  logic [DW-1:0] m_d;
  logic        m_err;
  logic [AW-1:0] ra [NREQ];
  logic [DW-1:0] rd [NREQ];

  initial begin
    reset = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    claim_valid = 1'b0; claim_addr = '0; rd1_addr = '0; rd2_addr = '0;

    //           rst v  a0 a1 a2  d0            d1      d2  cv ca r1 | rdy wen w   data         busy cnt err
    vecs.push_back(mk(0, 7, 1, 2, 3, 0,            0,      0,  1, 9, 9,   0, 0, 0,  0,            0, 0, 0));
    vecs.push_back(mk(1, 1, 5, 0, 0, 32'hDEADBEEF, 0,      0,  0, 0, 9,   1, 0, 0,  0,            0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  0, 0, 9,   0, 1, 5,  32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  0, 0, 9,   0, 0, 5,  32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0,      0,  0, 0, 9,   0, 0, 5,  32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 2, 3, 10,           11,     12, 0, 0, 0,   1, 0, 0,  0,            0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 2, 3, 10,           11,     12, 0, 0, 0,   2, 1, 1,  10,           0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 2, 3, 10,           11,     12, 0, 0, 0,   4, 1, 2,  11,           0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 2, 3, 10,           11,     12, 0, 0, 0,   1, 1, 3,  12,           0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 2, 3, 10,           11,     12, 0, 0, 0,   2, 1, 1,  10,           0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 2, 3, 10,           11,     12, 0, 0, 0,   4, 1, 2,  11,           0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  0, 0, 0,   0, 1, 3,  12,           0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  1, 12, 12, 0, 0, 3,  12,           0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 12, 0, 0,           'h1234, 0,  0, 0, 12,  2, 0, 3,  12,           1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  0, 0, 12,  0, 1, 12, 'h1234,       0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  1, 7, 7,   0, 0, 12, 'h1234,       0, 0, 0));
    vecs.push_back(mk(1, 1, 7, 0, 0, 'h77,         0,      0,  1, 7, 7,   1, 0, 12, 'h1234,       1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  1, 7, 7,   0, 1, 7,  'h77,         1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  0, 0, 7,   0, 0, 7,  'h77,         1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0,      0,  0, 0, 7,   0, 0, 7,  'h77,         1, 1, 0));

    @(negedge clk);
    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i], i);

    // Mid-operation reset: three more claims on top of pending[7], a grant in flight, then reset.
    reset = 1'b1; req_valid = '0; claim_valid = 1'b1;
    claim_addr = 6'd20; @(negedge clk);
    claim_addr = 6'd21; @(negedge clk);
    claim_addr = 6'd22; @(negedge clk);
    claim_valid = 1'b0; rd1_addr = 6'd20;
    req_valid = 3'b111;
    req_addr  = {6'd33, 6'd32, 6'd31};
    req_data  = {32'hC, 32'hB, 32'hA};
    #1;
    check("mid pend_count before reset", 64'(pend_count), 64'd4);
    check("mid rd1_busy before reset",   64'(rd1_busy),   64'd1);
    check("mid grant before reset",      64'(req_ready),  64'b010);
    @(negedge clk);
    reset = 1'b0; #1;
    check("mid ready during reset",      64'(req_ready),  64'd0);
    check("mid last write registered",   64'(rf_W),       64'd32);
    check("mid last data registered",    64'(rf_Data_in), 64'hB);
    @(negedge clk);
    reset = 1'b1; #1;
    check("post-reset rf_W_en",          64'(rf_W_en),    64'd0);
    check("post-reset rf_W",             64'(rf_W),       64'd0);
    check("post-reset rf_Data_in",       64'(rf_Data_in), 64'd0);
    check("post-reset pend_count",       64'(pend_count), 64'd0);
    check("post-reset rd1_busy",         64'(rd1_busy),   64'd0);
    check("post-reset claim_err",        64'(claim_err),  64'd0);
    check("post-reset first grant",      64'(req_ready),  64'b001);
    @(negedge clk);
    req_valid = '0; #1;
    check("post-reset write addr",       64'(rf_W),       64'd31);
    check("post-reset write data",       64'(rf_Data_in), 64'hA);
    @(negedge clk);

    // Randomized traffic against the reference model, starting from a clean reset.
    reset = 1'b0; claim_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_ptr = 0; m_wen = 1'b0; m_w = '0; m_d = '0; m_err = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      int cnt;
      int vbits;
      logic [NREQ-1:0] exp_ready;
      reset = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < NREQ; i++) begin
        ra[i] = AW'($urandom_range(0, 15));
        rd[i] = DW'($urandom());
      end
      req_valid   = NREQ'($urandom_range(0, 7));
      req_addr    = {ra[2], ra[1], ra[0]};
      req_data    = {rd[2], rd[1], rd[0]};
      claim_valid = ($urandom_range(0, 2) == 0);
      claim_addr  = AW'($urandom_range(0, 15));
      rd1_addr    = AW'($urandom_range(0, 15));
      rd2_addr    = AW'($urandom_range(0, 15));
      #1;

      g = -1;
      vbits = int'(req_valid);
      if (reset) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && ((vbits >> idx) & 1) == 1) g = idx;
        end
      end
      exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
      cnt = 0;
      foreach (m_pend[i]) cnt += int'(m_pend[i]);

      check($sformatf("rand%0d req_ready", cyc),  64'(req_ready),  64'(exp_ready));
      check($sformatf("rand%0d rd1_busy", cyc),   64'(rd1_busy),   64'(m_pend[rd1_addr]));
      check($sformatf("rand%0d rd2_busy", cyc),   64'(rd2_busy),   64'(m_pend[rd2_addr]));
      check($sformatf("rand%0d pend_count", cyc), 64'(pend_count), 64'(cnt));
      check($sformatf("rand%0d rf_W_en", cyc),    64'(rf_W_en),    64'(m_wen));
      check($sformatf("rand%0d rf_W", cyc),       64'(rf_W),       64'(m_w));
      check($sformatf("rand%0d rf_Data_in", cyc), 64'(rf_Data_in), 64'(m_d));
      check($sformatf("rand%0d claim_err", cyc),  64'(claim_err),  64'(m_err));

      if (!reset) begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_ptr = 0; m_wen = 1'b0; m_w = '0; m_d = '0; m_err = 1'b0;
      end else begin
        m_err = claim_valid && m_pend[claim_addr] && !(g >= 0 && ra[g] == claim_addr);
        if (g >= 0) begin
          m_wen = 1'b1;
          m_w   = ra[g];
          m_d   = rd[g];
          m_ptr = (g + 1) % NREQ;
          m_pend[ra[g]] = 1'b0;
        end else begin
          m_wen = 1'b0;
        end
        if (claim_valid) m_pend[claim_addr] = 1'b1;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 3: number of write-back requesters (2..8).
REQ-002 The block SHALL have parameter AW, default 6: register address width (64 registers).
REQ-003 The block SHALL have parameter DW, default 32: register data width.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, NREQ: per-requester write request.
REQ-007 The block SHALL have port req_addr, input, NREQ*AW: per-requester destination register, requester i at bits [i*AW +: AW].
REQ-008 The block SHALL have port req_data, input, NREQ*DW: per-requester write data, requester i at bits [i*DW +: DW].
REQ-009 The block SHALL have port req_ready, output, NREQ: per-requester grant, combinational.
REQ-010 The block SHALL have port rf_W, output, AW: register-file write address, registered.
REQ-011 The block SHALL have port rf_Data_in, output, DW: register-file write data, registered.
REQ-012 The block SHALL have port rf_W_en, output, 1: register-file write enable, registered.
REQ-013 The block SHALL have port claim_valid, input, 1: issue stage reserves a destination register.
REQ-014 The block SHALL have port claim_addr, input, AW: register being reserved.
REQ-015 The block SHALL have port claim_err, output, 1: registered one-cycle pulse, claim of an already-pending register.
REQ-016 The block SHALL have port rd1_addr and rd2_addr, input, AW each: source registers queried by issue.
REQ-017 The block SHALL have port rd1_busy and rd2_busy, output, 1 each: combinational pending[rdN_addr].
REQ-018 The block SHALL have port pend_count, output, AW+1: registered count of pending registers.

Function
REQ-019 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-020 req_ready SHALL be one-hot or zero; req_ready[i] only when req_valid[i]=1; never while reset=0.
REQ-021 Arbitration SHALL be round-robin: grant the first valid requester scanning from rr_ptr upward, modulo NREQ.
REQ-022 After a grant to i, rr_ptr SHALL become (i+1) mod NREQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-023 After a transfer, the next edge SHALL load rf_W_en=1, rf_W=req_addr[i], rf_Data_in=req_data[i]: latency one cycle.
REQ-024 In a cycle with no transfer, the next edge SHALL set rf_W_en=0 while rf_W and rf_Data_in hold.
REQ-025 The block SHALL sustain one write per cycle with no bubbles under continuous requests.
REQ-026 A claim_valid at an edge SHALL set pending[claim_addr].
REQ-027 A transfer at an edge SHALL clear pending[req_addr[i]].
REQ-028 When a claim and a transfer target the same address at the same edge, the set SHALL win and pending stays 1.
REQ-029 A claim to an address already pending, with no same-edge clear, SHALL pulse claim_err=1 for one cycle; pending stays 1.
REQ-030 A transfer to a non-pending address SHALL still be written; pending is unchanged.
REQ-031 rd1_busy and rd2_busy SHALL reflect the registered pending state and SHALL NOT bypass same-cycle claims or clears.
REQ-032 pend_count SHALL equal the population count of pending after each edge, 0..2^AW.

Reset
REQ-033 At a rising edge with reset=0, the block SHALL clear: pending, rr_ptr, rf_W_en, rf_W, rf_Data_in, claim_err and pend_count, all to 0.
REQ-034 While reset=0, req_ready SHALL be 0; claims and requests in that cycle SHALL be discarded.
REQ-035 A reset asserted mid-stream SHALL drop any write not yet registered, with no partial write.

Verification
REQ-036 Single write: req_valid=001, addr0=5, data0=0xDEADBEEF -> req_ready=001 same cycle; next cycle rf_W_en=1, rf_W=5, rf_Data_in=0xDEADBEEF; following cycle rf_W_en=0.
REQ-037 Fairness: req_valid=111 held 6 cycles after reset -> grants 0,1,2,0,1,2; rf_W_en=1 on every cycle 2..7.
REQ-038 Scoreboard: claim 12 -> rd1_addr=12 gives rd1_busy=1 the next cycle; requester 1 writes 12 -> busy=0 and pend_count back to 0 one cycle after the transfer.
REQ-039 Collision: pending[7]=1; same-edge claim 7 and transfer to 7 -> pending[7]=1, claim_err=0; a second claim 7 -> claim_err=1 for exactly one cycle.
REQ-040 Mid-operation reset: claim 3 registers, req_valid=111, then reset=0 for one edge -> all outputs 0, pend_count=0; first grant after release goes to requester 0.
